fp_ftoi_issue: RTL

Request-side front end for the float-to-integer converter pipeline `fp_ftoi`. It accepts tagged conversion requests from the FP dispatch stage over a valid/ready handshake and buffers them. It feeds operands to the converter, which is fixed-latency and non-stallable, one per cycle. It then re-associates each integer result with its tag and holds results in an output buffer until writeback accepts them. Credit-based issue guarantees that no converter result is ever dropped.

---
 rtl/gpu_parameters.sv | 20 ++
 rtl/gpu_sync_fifo.sv | 59 +++++
 rtl/fp_ftoi_issue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/gpu_parameters.sv
// Shared GPU parameters and converter request/result payloads.
package gpu_parameters;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned TAG_WIDTH    = 5;
  localparam int unsigned FTOI_LATENCY = 2;

  // Conversion request: IEEE-754 single operand plus destination tag.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] fval;
    logic [TAG_WIDTH-1:0]  tag;
  } fp_cvt_req_t;

  // Conversion result: integer value plus destination tag.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] ival;
    logic [TAG_WIDTH-1:0]  tag;
  } fp_cvt_res_t;

endpackage

// File: rtl/gpu_sync_fifo.sv
// Synchronous show-ahead FIFO with registered write-ready and read-valid flags.
// wr_ready is held low while in reset so it can be used directly as an
// upstream ready that comes out of reset deasserted.
module gpu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_ready,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr_c;
  logic             do_rd_c;
  logic [CW-1:0]    count_next_c;

  // Qualified push/pop and next occupancy.
  always_comb begin
    do_wr_c      = wr_en && wr_ready;
    do_rd_c      = rd_en && rd_valid;
    count_next_c = count + CW'(do_wr_c) - CW'(do_rd_c);
  end

  // Storage, pointers, count and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (do_wr_c) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd_c) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next_c;
      wr_ready <= (count_next_c != CW'(DEPTH));
      rd_valid <= (count_next_c != '0);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fp_ftoi_issue.sv
// Request-side front end for the fp_ftoi converter: buffers tagged requests,
// issues one operand per cycle under result-buffer credits, re-tags results.
// Optional same-cycle bypass of an empty request FIFO: FP_FTOI_ISSUE_BYPASS_EN.
module fp_ftoi_issue
  import gpu_parameters::*;
#(
  parameter int unsigned IN_DEPTH    = 4,
  parameter int unsigned OUT_DEPTH   = 4,
  parameter int unsigned CVT_LATENCY = FTOI_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_float,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic [DATA_WIDTH-1:0] cvt_float,
  input  logic [DATA_WIDTH-1:0] cvt_int,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_int,
  output logic [TAG_WIDTH-1:0]  res_tag,
  output logic                  busy
);

  localparam int unsigned ICW = $clog2(IN_DEPTH) + 1;
  localparam int unsigned OCW = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned FW  = $clog2(CVT_LATENCY + 1);
  localparam int unsigned SW  = $clog2(OUT_DEPTH + CVT_LATENCY + 1);

  fp_cvt_req_t          req_in_c;
  fp_cvt_req_t          in_head;
  logic                 in_valid;
  logic [ICW-1:0]       in_count;
  fp_cvt_res_t          res_in_c;
  fp_cvt_res_t          res_head;
  logic                 res_wr_ready;
  logic [OCW-1:0]       res_count;

  logic [CVT_LATENCY-1:0] sr_valid;
  logic [TAG_WIDTH-1:0]   sr_tag [CVT_LATENCY];

  logic                 accept_c;
  logic                 credit_ok_c;
  logic                 fifo_issue_c;
  logic                 bypass_c;
  logic                 in_wr_c;
  logic                 issue_c;
  logic [TAG_WIDTH-1:0] issue_tag_c;
  logic [FW-1:0]        inflight_c;

  assign req_in_c = '{fval: req_float, tag: req_tag};
  assign res_in_c = '{ival: cvt_int, tag: sr_tag[CVT_LATENCY-1]};

  // Request FIFO.
  gpu_sync_fifo #(.WIDTH($bits(fp_cvt_req_t)), .DEPTH(IN_DEPTH)) u_req_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (in_wr_c),
    .wr_data  (req_in_c),
    .wr_ready (req_ready),
    .rd_en    (fifo_issue_c),
    .rd_data  (in_head),
    .rd_valid (in_valid),
    .count    (in_count)
  );

  // Credits: occupancy at cycle start plus in-flight must leave a free slot.
  always_comb begin
    inflight_c = '0;
    for (int unsigned i = 0; i < CVT_LATENCY; i++) inflight_c = inflight_c + FW'(sr_valid[i]);
    credit_ok_c  = (SW'(res_count) + SW'(inflight_c)) < SW'(OUT_DEPTH);
    accept_c     = req_valid && req_ready;
    fifo_issue_c = in_valid && credit_ok_c;
`ifdef FP_FTOI_ISSUE_BYPASS_EN
    bypass_c     = !in_valid && credit_ok_c && accept_c;
`else
    bypass_c     = 1'b0;
`endif
    in_wr_c      = accept_c && !bypass_c;
  end

  // Operand mux: FIFO head, bypassed request, or zero when idle.
  always_comb begin
    cvt_float   = '0;
    issue_c     = 1'b0;
    issue_tag_c = '0;
    if (fifo_issue_c) begin
      cvt_float   = in_head.fval;
      issue_tag_c = in_head.tag;
      issue_c     = 1'b1;
    end else if (bypass_c) begin
      cvt_float   = req_float;
      issue_tag_c = req_tag;
      issue_c     = 1'b1;
    end
  end

  // Valid/tag shift register tracking the converter pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_valid <= '0;
      for (int unsigned i = 0; i < CVT_LATENCY; i++) sr_tag[i] <= '0;
    end else begin
      sr_valid[0] <= issue_c;
      sr_tag[0]   <= issue_tag_c;
      for (int unsigned i = 1; i < CVT_LATENCY; i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_tag[i]   <= sr_tag[i-1];
      end
    end
  end

  // Result buffer; writes are credit-protected and never blocked.
  gpu_sync_fifo #(.WIDTH($bits(fp_cvt_res_t)), .DEPTH(OUT_DEPTH)) u_res_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (sr_valid[CVT_LATENCY-1]),
    .wr_data  (res_in_c),
    .wr_ready (res_wr_ready),
    .rd_en    (res_ready),
    .rd_data  (res_head),
    .rd_valid (res_valid),
    .count    (res_count)
  );

  // A converter result arriving at a full result buffer would be lost.
  a_no_result_drop: assert property (@(posedge clk) disable iff (!rst_n)
    sr_valid[CVT_LATENCY-1] |-> res_wr_ready);

  assign res_int = res_head.ival;
  assign res_tag = res_head.tag;
  assign busy    = (in_count != '0) || (inflight_c != '0) || res_valid;

endmodule
